// File: rtl/gpu_register_file_mt.sv
// Multi-threaded GPU register file: one private bank of NUM_REGS x DATA_W per
// hardware thread, one write port and two registered read ports (A/B).
// After reset a clear sweep zeroes every entry before ready is raised.
module gpu_register_file_mt #(
    parameter  int DATA_W      = 64,
    parameter  int NUM_REGS    = 32,
    parameter  int NUM_THREADS = 4,
    parameter  int BYPASS      = 1,
    parameter  int ZERO_REG    = 0,
    localparam int ADDR_W      = $clog2(NUM_REGS),
    localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              wr_en,
    input  logic [TID_W-1:0]  wr_tid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [TID_W-1:0]  rd_tid,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid
);

    localparam int TBITS = $clog2(NUM_THREADS);
    localparam int IDX_W = ADDR_W + TBITS;
    localparam int DEPTH = NUM_THREADS * NUM_REGS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    // One extra bit so NUM_THREADS itself is representable for the range check
    localparam logic [TID_W:0]   NT       = (TID_W + 1)'(NUM_THREADS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_tid_ok, rd_tid_ok, wr_fire;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] nxt_a, nxt_b;

    // Flat index is {tid, addr}; with a single thread the tid bit is dropped
    function automatic logic [IDX_W-1:0] to_idx(input logic [TID_W-1:0] tid,
                                                 input logic [ADDR_W-1:0] addr);
        logic [TID_W+ADDR_W-1:0] full;
        full = {tid, addr};
        return full[IDX_W-1:0];
    endfunction

    // Read value for one port: zero register and bad tid win over bypass,
    // bypass only fires on an exact same-thread/same-register write
    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = mem[to_idx(rd_tid, addr)];
        if (BYPASS != 0 && wr_fire && wr_tid == rd_tid && wr_addr == addr)
            val = wr_data;
        if (!rd_tid_ok || (ZERO_REG != 0 && addr == '0))
            val = '0;
        return val;
    endfunction

    // Port qualification and next read data
    always_comb begin
        wr_tid_ok = {1'b0, wr_tid} < NT;
        rd_tid_ok = {1'b0, rd_tid} < NT;
        wr_idx    = to_idx(wr_tid, wr_addr);
        wr_fire   = (state == RUN) && wr_en && wr_tid_ok &&
                    !(ZERO_REG != 0 && wr_addr == '0);
        nxt_a     = rd_word(rd_addr_a);
        nxt_b     = rd_word(rd_addr_b);
    end

    // Storage: the sweep zeroes one entry per cycle, normal writes only in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clr_ptr] <= '0;
            else if (wr_fire)
                mem[wr_idx] <= wr_data;
        end
    end

    // Control FSM plus registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            ready     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    rd_valid <= 1'b0;
                    clr_ptr  <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        rd_data_a <= nxt_a;
                        rd_data_b <= nxt_b;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
